// File: rtl/bus_addr_dec_fsm_pkg.sv
// Shared types and defaults for the registered bus slave-select decoder.
package bus_addr_dec_fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ERR    = 2'd2
  } state_t;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_SEL_BITS    = 3;
  localparam int DEF_NUM_SLAVES  = 8;
  localparam int DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/bus_addr_dec_fsm_onehot.sv
// Combinational slave index to one-hot select with range check; zero latency, no flow control.
module bus_addr_dec_fsm_onehot
  import bus_addr_dec_fsm_pkg::*;
#(
  parameter int SEL_BITS   = DEF_SEL_BITS,
  parameter int NUM_SLAVES = DEF_NUM_SLAVES
) (
  input  logic [SEL_BITS-1:0]   idx,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic                  valid
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      onehot[i] = (int'(idx) == i);
    end
    // Constant-true when every index is mapped, so the error path folds away.
    valid = (int'(idx) < NUM_SLAVES);
  end

endmodule

// File: rtl/bus_addr_dec_fsm.sv
// Registered slave-select decoder: cs rises one edge after req, held until the selected slave is ready.
// Requests while busy are dropped, not queued; optional ACCESS timeout under BUS_DEC_TIMEOUT_EN.
module bus_addr_dec_fsm
  import bus_addr_dec_fsm_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SEL_BITS    = DEF_SEL_BITS,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [NUM_SLAVES-1:0] s_rdy,
  output logic [NUM_SLAVES-1:0] cs,
  output logic [SEL_BITS-1:0]   sel_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t                  state;
  logic [SEL_BITS-1:0]     idx;
  logic [NUM_SLAVES-1:0]   idx_onehot;
  logic                    idx_valid;
  logic                    rdy_hit;
  logic                    unused_bits;

  assign idx = addr[ADDR_W-1 -: SEL_BITS];

  bus_addr_dec_fsm_onehot #(
    .SEL_BITS   (SEL_BITS),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_onehot (
    .idx    (idx),
    .onehot (idx_onehot),
    .valid  (idx_valid)
  );

  // cs is one-hot on sel_idx during ACCESS, so masking s_rdy with it picks s_rdy[sel_idx].
  assign rdy_hit     = |(s_rdy & cs);
  assign busy        = (state != S_IDLE);
  assign unused_bits = (^addr[ADDR_W-SEL_BITS-1:0]) ^ (TIMEOUT_CYC == 0);

`ifdef BUS_DEC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cs      <= '0;
      sel_idx <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef BUS_DEC_TIMEOUT_EN
      tmo_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            sel_idx <= idx;
            if (idx_valid) begin
              cs    <= idx_onehot;
              state <= S_ACCESS;
`ifdef BUS_DEC_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_ACCESS: begin
          // Ready takes priority over a timeout landing on the same edge.
          if (rdy_hit) begin
            cs    <= '0;
            done  <= 1'b1;
            state <= S_IDLE;
          end
`ifdef BUS_DEC_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            cs    <= '0;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end
        S_ERR: begin
          done  <= 1'b1;
          err   <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          cs    <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_addr_dec_fsm.sv
// Directed plus random checks of bus_addr_dec_fsm against a transaction-level reference model.
module tb_bus_addr_dec_fsm;
  import bus_addr_dec_fsm_pkg::*;

  localparam int AW  = 32;
  localparam int SB  = 3;
  localparam int NS  = 6;
  localparam int TMO = 4;
`ifdef BUS_DEC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic [AW-1:0] addr;
  logic [NS-1:0] s_rdy;
  logic [NS-1:0] cs;
  logic [SB-1:0] sel_idx;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  // Reference model: which slave is being waited on (-1 = none), pending error, wait count.
  int m_slave = -1;
  bit m_errp  = 1'b0;
  int m_wait  = 0;
  int m_sel   = 0;
  bit m_done  = 1'b0;
  bit m_err   = 1'b0;

  always #5 clk = ~clk;

  bus_addr_dec_fsm #(
    .ADDR_W      (AW),
    .SEL_BITS    (SB),
    .NUM_SLAVES  (NS),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .addr    (addr),
    .s_rdy   (s_rdy),
    .cs      (cs),
    .sel_idx (sel_idx),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic q, input logic [AW-1:0] a, input logic [NS-1:0] s);
    int idx;
    if (!r) begin
      m_slave = -1; m_errp = 1'b0; m_wait = 0; m_sel = 0; m_done = 1'b0; m_err = 1'b0;
      return;
    end
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_errp) begin
      m_done = 1'b1; m_err = 1'b1; m_errp = 1'b0;
    end else if (m_slave >= 0) begin
      if (s[m_slave]) begin
        m_done = 1'b1; m_slave = -1;
      end else begin
        m_wait++;
        if (TMO_EN && m_wait == TMO) begin
          m_done = 1'b1; m_err = 1'b1; m_slave = -1;
        end
      end
    end else if (q) begin
      idx   = int'(a >> (AW - SB));
      m_sel = idx;
      if (idx < NS) begin
        m_slave = idx; m_wait = 0;
      end else begin
        m_errp = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic q, input logic [AW-1:0] a, input logic [NS-1:0] s);
    logic [31:0] exp_cs;
    reset = r; req = q; addr = a; s_rdy = s;
    @(posedge clk);
    model(r, q, a, s);
    #1;
    exp_cs = (m_slave >= 0) ? (32'd1 << m_slave) : 32'd0;
    chk("cs",      32'(cs),      exp_cs);
    chk("sel_idx", 32'(sel_idx), 32'(m_sel));
    chk("busy",    32'(busy),    32'((m_slave >= 0) || m_errp));
    chk("done",    32'(done),    32'(m_done));
    chk("err",     32'(err),     32'(m_err));
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; addr = '0; s_rdy = '0;
    // Reset state
    step(1'b0, 1'b0, 32'h0, 6'h00);
    step(1'b0, 1'b1, 32'h6000_0000, 6'h3F);

    // Slow slave 3: three idle ready cycles, then ready
    step(1'b1, 1'b1, 32'h6000_0000, 6'h00);
    repeat (3) step(1'b1, 1'b0, 32'h6000_0000, 6'h00);
    step(1'b1, 1'b0, 32'h6000_0000, 6'h08);
    step(1'b1, 1'b0, 32'h6000_0000, 6'h00);

    // Single-cycle slave 0
    step(1'b1, 1'b1, 32'h0000_0010, 6'h3F);
    step(1'b1, 1'b0, 32'h0000_0010, 6'h3F);
    step(1'b1, 1'b0, 32'h0000_0010, 6'h3F);

    // Unmapped index 7, then unmapped index 6 (boundary)
    step(1'b1, 1'b1, 32'hE000_0000, 6'h00);
    step(1'b1, 1'b0, 32'hE000_0000, 6'h00);
    step(1'b1, 1'b1, 32'hC000_0000, 6'h00);
    step(1'b1, 1'b0, 32'hC000_0000, 6'h00);
    step(1'b1, 1'b0, 32'hC000_0000, 6'h00);

    // Mid-access reset on slave 5
    step(1'b1, 1'b1, 32'hA000_0000, 6'h00);
    step(1'b1, 1'b0, 32'hA000_0000, 6'h00);
    step(1'b0, 1'b0, 32'hA000_0000, 6'h00);
    step(1'b1, 1'b0, 32'hA000_0000, 6'h00);

    // Slave 2 access ignores a new address and a foreign ready
    step(1'b1, 1'b1, 32'h4000_0000, 6'h00);
    step(1'b1, 1'b1, 32'hA000_0000, 6'h20);
    step(1'b1, 1'b1, 32'hA000_0000, 6'h3B);
    step(1'b1, 1'b0, 32'hA000_0000, 6'h04);
    // Back-to-back: request accepted on the edge right after done
    step(1'b1, 1'b1, 32'h2000_0000, 6'h00);
    step(1'b1, 1'b0, 32'h2000_0000, 6'h02);
    step(1'b1, 1'b0, 32'h2000_0000, 6'h00);

    // Slave never ready, then ready in the fourth access cycle
    step(1'b1, 1'b1, 32'h8000_0000, 6'h00);
    repeat (5) step(1'b1, 1'b0, 32'h8000_0000, 6'h00);
    step(1'b1, 1'b1, 32'h8000_0000, 6'h00);
    repeat (3) step(1'b1, 1'b0, 32'h8000_0000, 6'h00);
    step(1'b1, 1'b0, 32'h8000_0000, 6'h10);
    step(1'b1, 1'b0, 32'h8000_0000, 6'h10);
    // Clear any access still pending in the untimed build
    step(1'b0, 1'b0, 32'h0, 6'h00);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic          r;
      logic          q;
      logic [AW-1:0] a;
      logic [NS-1:0] s;
      r = ($urandom_range(0, 59) != 0);
      q = ($urandom_range(0, 1) == 1);
      a = $urandom;
      s = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
      step(r, q, a, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
